// File: rtl/off_chip_sink_if.sv
// off_chip_sink_if: upstream 64-bit stream plus downstream forwarded-packet port of the sink
interface off_chip_sink_if;
  logic [63:0] data_in;
  logic        valid_in;
  logic        ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  modport slave (input data_in, valid_in, out_ready, output ready, out_data, out_valid, out_last);
  modport master (output data_in, valid_in, out_ready, input ready, out_data, out_valid, out_last);
endinterface

// File: rtl/off_chip_sink.sv
// off_chip_sink: frames header/payload/XOR-trailer packets, buffers one packet and forwards only clean ones
module off_chip_sink #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] MAGIC = 8'hA5,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  off_chip_sink_if.slave   bus,
  output logic [CNT_W-1:0] pkt_ok_cnt,
  output logic [CNT_W-1:0] pkt_err_cnt,
  output logic             err_pulse
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER, DRAIN} state_t;
  state_t           r_state, w_next;
  logic             r_ready, r_err_pulse;
  logic [7:0]       r_len;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [63:0]      r_xor;
  logic [63:0]      r_buf [DEPTH];
  logic [CNT_W-1:0] r_ok, r_err;
  logic             w_acc, w_out_hs, w_legal, w_match, w_wlast, w_rlast, w_ok, w_err;
  assign w_acc    = bus.valid_in && r_ready;
  assign w_out_hs = bus.out_valid && bus.out_ready;
  assign w_legal  = bus.data_in[63:56] == MAGIC && bus.data_in[7:0] != 8'd0 && bus.data_in[7:0] <= 8'(DEPTH);
  assign w_match  = bus.data_in == r_xor;
  assign w_wlast  = 8'(r_wptr) == r_len - 8'd1;
  assign w_rlast  = 8'(r_rptr) == r_len - 8'd1;
  assign w_ok     = w_acc && r_state == TRAILER && w_match;
  assign w_err    = w_acc && ((r_state == IDLE && !w_legal) || (r_state == TRAILER && !w_match));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_acc && w_legal) ? PAYLOAD : IDLE;
      PAYLOAD: w_next = (w_acc && w_wlast) ? TRAILER : PAYLOAD;
      TRAILER: w_next = w_acc ? (w_match ? DRAIN : IDLE) : TRAILER;
      DRAIN:   w_next = (w_out_hs && w_rlast) ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // ready is registered so it is low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_len       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_xor       <= '0;
      r_ok        <= '0;
      r_err       <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ready     <= w_next != DRAIN;
      r_err_pulse <= w_err;
      if (r_state == IDLE && w_acc && w_legal) begin
        r_len  <= bus.data_in[7:0];
        r_xor  <= '0;
        r_wptr <= '0;
      end
      if (r_state == PAYLOAD && w_acc) begin
        r_wptr <= r_wptr + 1'b1;
        r_xor  <= r_xor ^ bus.data_in;
      end
      if (w_ok) r_rptr <= '0;
      if (r_state == DRAIN && w_out_hs) r_rptr <= r_rptr + 1'b1;
      if (w_ok && r_ok != '1) r_ok <= r_ok + 1'b1;
      if (w_err && r_err != '1) r_err <= r_err + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == PAYLOAD && w_acc) r_buf[r_wptr] <= bus.data_in;
  end
  assign bus.ready     = r_ready;
  assign bus.out_valid = r_state == DRAIN;
  assign bus.out_data  = bus.out_valid ? r_buf[r_rptr] : '0;
  assign bus.out_last  = bus.out_valid && w_rlast;
  assign pkt_ok_cnt    = r_ok;
  assign pkt_err_cnt   = r_err;
  assign err_pulse     = r_err_pulse;
endmodule

// File: tb/tb_off_chip_sink.sv
// tb_off_chip_sink: randomized packets against a queue-based packet model of the sink
module tb_off_chip_sink;
  localparam int DEPTH = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ok_cnt, err_cnt;
  logic        err_pulse;
  int          checks = 0, errors = 0;
  int          exp_ok = 0, exp_err = 0, exp_pulses = 0, pulses = 0, or_mode = 0;
  logic [64:0] expq[$];
  logic [63:0] pl[$];

  off_chip_sink_if bif();
  off_chip_sink #(.DEPTH(DEPTH), .MAGIC(8'hA5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bif), .pkt_ok_cnt(ok_cnt), .pkt_err_cnt(err_cnt), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] w, input int gap);
    bit hs = 0;
    int n = 0;
    repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    bif.data_in  = w;
    bif.valid_in = 1'b1;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = bif.ready;
      @(posedge clk);
      #1;
      n++;
    end
    bif.valid_in = 1'b0;
    check("send_hs", 64'(hs), 64'd1);
  endtask

  task automatic run_pkt(input logic [7:0] mg, input logic [7:0] len, input logic [63:0] flip, input int gap);
    logic [63:0] x = '0;
    bit legal;
    legal = mg == 8'hA5 && len >= 1 && len <= DEPTH;
    send_word({mg, 32'($urandom), 16'($urandom), len}, gap);
    if (!legal) begin
      exp_err++;
      exp_pulses++;
      check("hdr_err_pulse", 64'(err_pulse), 64'd1);
      check("hdr_ready", 64'(bif.ready), 64'd1);
      check("hdr_no_out", 64'(bif.out_valid), 64'd0);
    end else begin
      if (pl.size() == 0) repeat (len) pl.push_back({$urandom, $urandom});
      foreach (pl[i]) begin
        x ^= pl[i];
        send_word(pl[i], gap);
      end
      send_word(x ^ flip, gap);
      if (flip == '0) begin
        exp_ok++;
        foreach (pl[i]) expq.push_back({i == int'(len) - 1, pl[i]});
        check("latency_valid", 64'(bif.out_valid), 64'd1);
        check("drain_ready", 64'(bif.ready), 64'd0);
      end else begin
        exp_err++;
        exp_pulses++;
        check("crc_err_pulse", 64'(err_pulse), 64'd1);
        check("crc_ready", 64'(bif.ready), 64'd1);
        check("crc_no_out", 64'(bif.out_valid), 64'd0);
      end
      pl.delete();
    end
    check("ok_cnt", 64'(ok_cnt), 64'(exp_ok));
    check("err_cnt", 64'(err_cnt), 64'(exp_err));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((expq.size() != 0 || bif.out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 64'(expq.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    bif.out_ready = or_mode == 0 ? 1'b1 : or_mode == 1 ? ~bif.out_ready : 1'($urandom_range(0, 1));
  end

  // output monitor: ordering, stall stability and the ready return after the last word
  initial begin
    logic [64:0] e, prev;
    bit have_prev, pend_last;
    have_prev = 0;
    pend_last = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_prev = 0;
        pend_last = 0;
      end else begin
        if (err_pulse) pulses++;
        if (pend_last) begin
          check("ready_after_last", 64'(bif.ready), 64'd1);
          check("valid_after_last", 64'(bif.out_valid), 64'd0);
          pend_last = 0;
        end
        if (have_prev) begin
          check("valid_held", 64'(bif.out_valid), 64'd1);
          check("data_held", bif.out_data, prev[63:0]);
          check("last_held", 64'(bif.out_last), 64'(prev[64]));
          have_prev = 0;
        end
        if (bif.out_valid && bif.out_ready) begin
          check("out_expected", 64'(expq.size() != 0), 64'd1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            check("out_data", bif.out_data, e[63:0]);
            check("out_last", 64'(bif.out_last), 64'(e[64]));
            if (bif.out_last) pend_last = 1;
          end
        end else if (bif.out_valid) begin
          prev = {bif.out_last, bif.out_data};
          have_prev = 1;
        end
      end
    end
  end

  initial begin
    int kind, len, gap;
    bif.valid_in  = 1'b0;
    bif.data_in   = '0;
    bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bif.ready), 64'd0);
    check("rst_out_valid", 64'(bif.out_valid), 64'd0);
    check("rst_out_last", 64'(bif.out_last), 64'd0);
    check("rst_out_data", bif.out_data, 64'd0);
    check("rst_ok_cnt", 64'(ok_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_err_pulse", 64'(err_pulse), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(bif.ready), 64'd1);
    or_mode = 0;
    pl = '{64'h1, 64'h2};
    run_pkt(8'hA5, 8'd2, 64'h0, 0);
    wait_drain();
    pl = '{64'h1, 64'h2};
    run_pkt(8'hA5, 8'd2, 64'h4, 0);
    @(posedge clk);
    #1;
    check("err_pulse_one_cycle", 64'(err_pulse), 64'd0);
    run_pkt(8'h5A, 8'd2, 64'h0, 0);
    run_pkt(8'hA5, 8'd0, 64'h0, 0);
    run_pkt(8'hA5, 8'(DEPTH + 1), 64'h0, 0);
    run_pkt(8'hA5, 8'd3, 64'h0, 0);
    wait_drain();
    or_mode = 1;
    run_pkt(8'hA5, 8'(DEPTH), 64'h0, 0);
    wait_drain();
    or_mode = 0;
    send_word({8'hA5, 48'h0, 8'd5}, 0);
    repeat (3) send_word({$urandom, $urandom}, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bif.ready), 64'd0);
    check("mid_rst_out_valid", 64'(bif.out_valid), 64'd0);
    check("mid_rst_out_data", bif.out_data, 64'd0);
    check("mid_rst_ok_cnt", 64'(ok_cnt), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    exp_ok  = 0;
    exp_err = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_mid_rst", 64'(bif.ready), 64'd1);
    run_pkt(8'hA5, 8'd4, 64'h0, 1);
    wait_drain();
    for (int k = 0; k < 60; k++) begin
      kind    = $urandom_range(0, 9);
      len     = $urandom_range(1, DEPTH);
      gap     = $urandom_range(0, 2);
      or_mode = $urandom_range(0, 2);
      case (kind)
        0:       run_pkt(8'hA5 ^ 8'($urandom_range(1, 255)), 8'(len), 64'h0, gap);
        1:       run_pkt(8'hA5, 8'd0, 64'h0, gap);
        2:       run_pkt(8'hA5, 8'($urandom_range(DEPTH + 1, 255)), 64'h0, gap);
        3:       run_pkt(8'hA5, 8'(len), {$urandom, $urandom} | 64'h1, gap);
        default: run_pkt(8'hA5, 8'(len), 64'h0, gap);
      endcase
    end
    or_mode = 0;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("err_pulse_total", 64'(pulses), 64'(exp_pulses));
    check("final_ok_cnt", 64'(ok_cnt), 64'(exp_ok));
    check("final_err_cnt", 64'(err_cnt), 64'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
